// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipelined RISC-V core datapath.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int CTRL_W_DEFAULT = 8;

endpackage

// File: rtl/fwd_predict.sv
// Predicts, at decode, which EX-stage forwarding source one source operand will need.
module fwd_predict
    import pipe_pkg::*;
(
    input  logic       used,
    input  logic [4:0] rs,
    input  logic       ex_valid,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       mem_valid,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    output fwd_sel_e   sel
);

    logic reads_real_reg;
    logic hit_ex;
    logic hit_mem;

    assign reads_real_reg = used && (rs != REG_X0);

    // A load in EX is not forwardable from MEM; the load-use bubble handles it.
    assign hit_ex  = reads_real_reg && ex_valid && ex_reg_write && !ex_mem_read && (ex_rd == rs);
    assign hit_mem = reads_real_reg && mem_valid && mem_reg_write && (mem_rd == rs);

    always_comb begin
        sel = FWD_RF;
        if (hit_ex) begin
            sel = FWD_MEM;
        end else if (hit_mem) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and registered forwarding selects.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_rd,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       PREOP1_EX,
    output logic [31:0]       PREOP2_EX,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        FWDA,
    output logic [1:0]        FWDB,
    output logic [CNT_W-1:0]  load_use_count
);

    fwd_sel_e sel_a;
    fwd_sel_e sel_b;
    logic     lu;
    logic     rs1_hit;
    logic     rs2_hit;

    fwd_predict u_fwd_a (
        .used          (id_rs1_used),
        .rs            (id_rs1),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .sel           (sel_a)
    );

    fwd_predict u_fwd_b (
        .used          (id_rs2_used),
        .rs            (id_rs2),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .sel           (sel_b)
    );

    assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
    assign lu      = id_valid && ex_valid && ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

    // Gated by rst so the stall output reads 0 while reset is held, as every other output does.
    assign stall_if_id = !rst && (mem_stall || (lu && !flush));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            PREOP1_EX      <= '0;
            PREOP2_EX      <= '0;
            ex_imm         <= '0;
            ex_rd          <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_ctrl        <= '0;
            FWDA           <= FWD_RF;
            FWDB           <= FWD_RF;
            load_use_count <= '0;
        end else if (mem_stall) begin
            ex_valid <= ex_valid;
        end else if (flush || lu) begin
            // Bubble: controls cleared, data fields left holding stale values.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_ctrl      <= '0;
            FWDA         <= FWD_RF;
            FWDB         <= FWD_RF;
            if (!flush && (load_use_count != '1)) begin
                load_use_count <= load_use_count + CNT_W'(1);
            end
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            PREOP1_EX    <= id_rdata1;
            PREOP2_EX    <= id_rdata2;
            ex_imm       <= id_imm;
            ex_rd        <= id_rd;
            ex_reg_write <= id_valid && id_reg_write;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_mem_write <= id_valid && id_mem_write;
            ex_ctrl      <= id_valid ? id_ctrl : '0;
            FWDA         <= sel_a;
            FWDB         <= sel_b;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: forwarding, load-use bubbles, flush, stall, reset.
module tb_id_ex_stage;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [4:0]        id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_rdata1;
    logic [31:0]       id_rdata2;
    logic [31:0]       id_imm;
    logic              mem_valid;
    logic              mem_reg_write;
    logic [4:0]        mem_rd;
    logic              flush;
    logic              mem_stall;
    logic              stall_if_id;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       PREOP1_EX;
    logic [31:0]       PREOP2_EX;
    logic [31:0]       ex_imm;
    logic [4:0]        ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [1:0]        FWDA;
    logic [1:0]        FWDB;
    logic [CNT_W-1:0]  load_use_count;

    int total;
    int bad;
    int expCount;

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_ctrl        (id_ctrl),
        .id_rdata1      (id_rdata1),
        .id_rdata2      (id_rdata2),
        .id_imm         (id_imm),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .flush          (flush),
        .mem_stall      (mem_stall),
        .stall_if_id    (stall_if_id),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .PREOP1_EX      (PREOP1_EX),
        .PREOP2_EX      (PREOP2_EX),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_ctrl        (ex_ctrl),
        .FWDA           (FWDA),
        .FWDB           (FWDB),
        .load_use_count (load_use_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic        valid,
        input logic [31:0] pc,
        input logic [4:0]  rs1,
        input logic        u1,
        input logic [4:0]  rs2,
        input logic        u2,
        input logic [4:0]  rd,
        input logic        rw,
        input logic        mr,
        input logic        mw,
        input logic [7:0]  ctrl,
        input logic [31:0] d1,
        input logic [31:0] d2,
        input logic [31:0] imm
    );
        id_valid     = valid;
        id_pc        = pc;
        id_rs1       = rs1;
        id_rs1_used  = u1;
        id_rs2       = rs2;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
        id_ctrl      = ctrl;
        id_rdata1    = d1;
        id_rdata2    = d2;
        id_imm       = imm;
    endtask

    task automatic setMem(input logic v, input logic rw, input logic [4:0] rd);
        mem_valid     = v;
        mem_reg_write = rw;
        mem_rd        = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        mem_stall = 1'b0;
        setMem(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_fwda", FWDA, 0);
        checkOutput("rst_fwdb", FWDB, 0);
        checkOutput("rst_count", load_use_count, 0);
        checkOutput("rst_stall", stall_if_id, 0);
        checkOutput("rst_op1", PREOP1_EX, 0);
        rst = 1'b0;

        // Back-to-back ALU dependence
        applyStimulus(1'b1, 32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 8'h11, 32'hAAAA, 32'hBBBB, 32'h4);
        tick();
        checkOutput("add_valid", ex_valid, 1);
        checkOutput("add_rd", ex_rd, 5);
        checkOutput("add_pc", ex_pc, 32'h100);
        checkOutput("add_op1", PREOP1_EX, 32'hAAAA);
        checkOutput("add_op2", PREOP2_EX, 32'hBBBB);
        checkOutput("add_imm", ex_imm, 32'h4);
        checkOutput("add_ctrl", ex_ctrl, 8'h11);
        checkOutput("add_rw", ex_reg_write, 1);
        checkOutput("add_fwda", FWDA, 0);
        applyStimulus(1'b1, 32'h104, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 8'h22, 32'h1, 32'h2, 32'h0);
        #1;
        checkOutput("b2b_stall", stall_if_id, 0);
        tick();
        checkOutput("b2b_fwda", FWDA, 2'b01);
        checkOutput("b2b_fwdb", FWDB, 2'b00);
        checkOutput("b2b_valid", ex_valid, 1);

        // Distance-2 dependence
        setMem(1'b1, 1'b1, 5'd5);
        applyStimulus(1'b1, 32'h108, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 8'h01, 32'h0, 32'h0, 32'h7);
        tick();
        setMem(1'b1, 1'b1, 5'd8);
        applyStimulus(1'b1, 32'h10C, 5'd11, 1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 8'h02, 32'h0, 32'h0, 32'h0);
        tick();
        setMem(1'b1, 1'b1, 5'd7);
        applyStimulus(1'b1, 32'h110, 5'd13, 1'b1, 5'd7, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 8'h03, 32'h0, 32'h0, 32'h0);
        tick();
        checkOutput("d2_fwdb", FWDB, 2'b10);
        checkOutput("d2_fwda", FWDA, 2'b00);

        // Load-use: one bubble, then WB forwarding
        setMem(1'b1, 1'b1, 5'd10);
        applyStimulus(1'b1, 32'h114, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 8'h04, 32'h0, 32'h0, 32'h0);
        tick();
        checkOutput("lw_memread", ex_mem_read, 1);
        setMem(1'b1, 1'b1, 5'd14);
        applyStimulus(1'b1, 32'h118, 5'd3, 1'b1, 5'd4, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 8'h05, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("lu_stall", stall_if_id, 1);
        tick();
        checkOutput("lu_bubble_valid", ex_valid, 0);
        checkOutput("lu_bubble_rw", ex_reg_write, 0);
        checkOutput("lu_bubble_mr", ex_mem_read, 0);
        checkOutput("lu_bubble_ctrl", ex_ctrl, 0);
        checkOutput("lu_bubble_fwda", FWDA, 0);
        checkOutput("lu_count", load_use_count, 1);
        setMem(1'b1, 1'b1, 5'd3);
        #1;
        checkOutput("lu_release_stall", stall_if_id, 0);
        tick();
        checkOutput("lu_fwda_wb", FWDA, 2'b10);
        checkOutput("lu_after_valid", ex_valid, 1);
        checkOutput("lu_after_rd", ex_rd, 15);
        checkOutput("lu_after_count", load_use_count, 1);

        // x0 never stalls or forwards
        setMem(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 32'h11C, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h06, 32'h0, 32'h0, 32'h0);
        tick();
        setMem(1'b1, 1'b1, 5'd15);
        applyStimulus(1'b1, 32'h120, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'h07, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("x0_stall", stall_if_id, 0);
        tick();
        checkOutput("x0_fwda", FWDA, 0);
        checkOutput("x0_fwdb", FWDB, 0);
        checkOutput("x0_valid", ex_valid, 1);

        // Double match, EX producer outranks an older MEM producer of the same register
        setMem(1'b1, 1'b0, 5'd0);
        applyStimulus(1'b1, 32'h124, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'h08, 32'h0, 32'h0, 32'h0);
        tick();
        setMem(1'b1, 1'b1, 5'd9);
        applyStimulus(1'b1, 32'h128, 5'd9, 1'b1, 5'd9, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 8'h09, 32'h0, 32'h0, 32'h0);
        tick();
        checkOutput("dbl_fwda", FWDA, 2'b01);
        checkOutput("dbl_fwdb", FWDB, 2'b01);

        // Flush together with load-use: flush wins
        setMem(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 32'h12C, 5'd1, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0, 8'h0A, 32'h0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h130, 5'd0, 1'b0, 5'd20, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 8'h0B, 32'h0, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        checkOutput("flush_lu_stall", stall_if_id, 0);
        tick();
        flush = 1'b0;
        checkOutput("flush_valid", ex_valid, 0);
        checkOutput("flush_rw", ex_reg_write, 0);
        checkOutput("flush_fwdb", FWDB, 0);
        checkOutput("flush_count", load_use_count, 1);

        // Invalid decode slot forces controls low but still captures data
        applyStimulus(1'b0, 32'h180, 5'd1, 1'b1, 5'd2, 1'b1, 5'd18, 1'b1, 1'b1, 1'b1, 8'hFF, 32'h0, 32'h0, 32'h0);
        tick();
        checkOutput("inv_valid", ex_valid, 0);
        checkOutput("inv_rw", ex_reg_write, 0);
        checkOutput("inv_mr", ex_mem_read, 0);
        checkOutput("inv_mw", ex_mem_write, 0);
        checkOutput("inv_ctrl", ex_ctrl, 0);
        checkOutput("inv_pc", ex_pc, 32'h180);

        // mem_stall freezes everything for 3 cycles
        setMem(1'b1, 1'b1, 5'd22);
        applyStimulus(1'b1, 32'h200, 5'd22, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0, 8'h5A, 32'h1234, 32'h5678, 32'h0);
        tick();
        checkOutput("pre_stall_fwda", FWDA, 2'b10);
        checkOutput("pre_stall_pc", ex_pc, 32'h200);
        applyStimulus(1'b1, 32'h300, 5'd1, 1'b1, 5'd2, 1'b1, 5'd23, 1'b0, 1'b1, 1'b1, 8'h00, 32'h9999, 32'h8888, 32'h0);
        setMem(1'b0, 1'b0, 5'd0);
        mem_stall = 1'b1;
        #1;
        checkOutput("mstall_stall", stall_if_id, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mstall_pc", ex_pc, 32'h200);
            checkOutput("mstall_rd", ex_rd, 21);
            checkOutput("mstall_ctrl", ex_ctrl, 8'h5A);
            checkOutput("mstall_op1", PREOP1_EX, 32'h1234);
            checkOutput("mstall_fwda", FWDA, 2'b10);
            checkOutput("mstall_mr", ex_mem_read, 0);
            checkOutput("mstall_stall_hold", stall_if_id, 1);
        end
        mem_stall = 1'b0;

        // Saturation of a 2-bit counter over 5 more load-use events
        expCount = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h400, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 8'h0C, 32'h0, 32'h0, 32'h0);
            tick();
            applyStimulus(1'b1, 32'h404, 5'd3, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 8'h0D, 32'h0, 32'h0, 32'h0);
            tick();
            expCount = (expCount == 3) ? 3 : expCount + 1;
            checkOutput("sat_count", load_use_count, expCount);
        end

        // Asynchronous reset in the middle of a stall
        applyStimulus(1'b1, 32'h500, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 8'h0E, 32'h77, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h504, 5'd3, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 8'h0F, 32'h0, 32'h0, 32'h0);
        mem_stall = 1'b1;
        #1;
        checkOutput("arst_pre_stall", stall_if_id, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_stall", stall_if_id, 0);
        checkOutput("arst_valid", ex_valid, 0);
        checkOutput("arst_count", load_use_count, 0);
        checkOutput("arst_pc", ex_pc, 0);
        checkOutput("arst_op1", PREOP1_EX, 0);
        checkOutput("arst_mr", ex_mem_read, 0);
        checkOutput("arst_rd", ex_rd, 0);
        #1;
        rst       = 1'b0;
        mem_stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage pipelined RISC-V core.
- Also detects load-use hazards at decode time and inserts a bubble.
- Pre-computes and registers the two operand-forwarding selects FWDA/FWDB. The EX-stage forwarding muxes consume these together with PREOP1_EX/PREOP2_EX.
- Sits between the decode stage (register file, immediate generator, control decoder) and the EX-stage forwarding muxes/ALU.

Parameters:
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle carried through (ALU op, ALU src, branch, etc.)
- CNT_W, 16, width of the saturating load-use stall counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  32  PC of decoded instruction
- id_rs1, id_rs2  in  5  source register indices
- id_rs1_used, id_rs2_used  in  1  instruction actually reads rs1/rs2
- id_rd  in  5  destination register index
- id_reg_write, id_mem_read, id_mem_write  in  1  decoded control
- id_ctrl  in  CTRL_W  remaining control bundle
- id_rdata1, id_rdata2  in  32  register file read data
- id_imm  in  32  generated immediate
- mem_valid, mem_reg_write  in  1  EX/MEM register state
- mem_rd  in  5  EX/MEM register state
- flush  in  1  taken branch/jump resolved in EX
- mem_stall  in  1  global back-pressure; freezes the pipeline
- stall_if_id  out  1  hold PC and IF/ID register this cycle
- ex_valid  out  1  EX slot valid
- ex_pc  out  32  registered id_pc
- PREOP1_EX, PREOP2_EX  out  32  registered operands
- ex_imm  out  32  registered immediate
- ex_rd  out  5  registered destination index
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- ex_ctrl  out  CTRL_W  registered control bundle
- FWDA, FWDB  out  2  registered forwarding selects: 00 register file, 01 MEM (ALUOUT_MEM), 10 WB (DATAW_WB)
- load_use_count  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset (asynchronous, rst=1): all outputs and registers 0; FWDA=FWDB=00; ex_valid=0; stall_if_id=0.
- Load-use hazard, combinational: lu = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Per-operand select prediction for operand n, evaluated at ID:
  - 01 if used & rs!=0 & ex_valid & ex_reg_write & ex_rd==rs & !ex_mem_read (producer will be in MEM).
  - Else 10 if used & rs!=0 & mem_valid & mem_reg_write & mem_rd==rs (producer will be in WB).
  - Else 00.
  - The MEM match has priority over WB, giving the youngest producer.
- The register file is write-before-read; no select covers the WB-to-ID case.
- Update priority on each rising clk edge:
  1. mem_stall=1: all registers hold, load_use_count holds.
  2. flush=1: ex_valid=0; all control outputs (reg_write, mem_read, mem_write, ctrl) 0; FWDA=FWDB=00; data outputs don't-care (hold).
  3. lu=1: bubble, cleared exactly as for flush; load_use_count increments, saturating at all ones.
  4. Otherwise: capture all id_* fields; ex_valid=id_valid; FWDA/FWDB take the predicted selects. If id_valid=0, control outputs are forced to 0.
- stall_if_id = mem_stall | (lu & !flush). During a flush, IF/ID is cleared by upstream logic rather than held.
- Load-use resolution: one bubble only. On the following cycle the load sits in MEM (mem_rd), so the held instruction re-evaluates to select 10.
- Latency: 1 cycle from ID to EX outputs.
- Boundary cases:
  - rd=x0 never forwards or stalls.
  - rs1==rs2 with a match: both selects are set identically.
  - Simultaneous flush and lu: flush wins, no count, no stall.
  - Reset asserted mid-stall: everything clears immediately.

Decomposition:
- Package pipe_pkg:
  - fwd_sel_e enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10)
  - REG_X0 constant
  - default CTRL_W
- Sub-module fwd_predict: combinational per-operand select computation, instantiated twice (rs1, rs2).

Test Plan:
- Back-to-back ALU dependence. Cycle N ID: add x5; cycle N+1 ID: sub reads rs1=x5 -> at N+2, FWDA=01, FWDB=00, ex_valid=1.
- Distance-2 dependence. Producer x7, one independent instruction, then consumer rs2=x7 -> FWDB=10.
- Load-use. lw x3 in EX (ex_mem_read=1), ID add rs1=x3:
  - stall_if_id=1 for one cycle; next EX is a bubble (ex_valid=0, controls 0); load_use_count=1.
  - The following cycle gives FWDA=10, ex_valid=1.
- x0 and double match. Consumer rs1=rs2=x0 with producer rd=x0 -> no stall, FWDA=FWDB=00. Consumer rs1=rs2=x9 with matching producer -> FWDA=FWDB=01.
- Flush vs stall. flush=1 in the same cycle as lu=1 -> ex_valid=0, stall_if_id=0, counter unchanged. mem_stall=1 for 3 cycles -> all outputs frozen, stall_if_id=1.
- Reset and saturation. rst pulsed mid-stall -> all outputs 0 asynchronously. With CNT_W=2, 5 load-use events -> load_use_count=3.
